// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter shared by instruction fetch (IF) and load/store (MEM).
// Each access is a run of little-endian byte transfers; results return per requester.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          MEM_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            din_ram,
  output logic [7:0]            dout_ram,
  output logic [ADDR_WIDTH-1:0] addr_ram,
  output logic                  wr_ram,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            n_q, n_d;
  logic                  own_if_q, own_if_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;

  logic [7:0]            dout_d;
  logic [ADDR_WIDTH-1:0] addr_ram_d;
  logic                  wr_d, if_done_d, mem_done_d, busy_d;
  logic [31:0]           if_inst_d, mem_rdata_d;

  logic                  grant_mem;
  logic [ADDR_WIDTH-1:0] sel_addr, nxt_addr;
  logic                  sel_we;
  logic [2:0]            sel_n;
  logic [31:0]           sel_wdata;
  logic [1:0]            nxt_idx, cap_idx;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    own_if_d    = own_if_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    dout_d      = dout_ram;
    addr_ram_d  = addr_ram;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst;
    mem_rdata_d = mem_rdata;

    grant_mem = mem_req && (MEM_FIRST || !if_req);
    sel_addr  = grant_mem ? mem_addr : if_addr;
    sel_we    = grant_mem && mem_we;
    sel_wdata = grant_mem ? mem_wdata : 32'h0;
    if (!grant_mem) sel_n = 3'd4;
    else if (mem_len == 2'b00) sel_n = 3'd1;
    else if (mem_len == 2'b01) sel_n = 3'd2;
    else sel_n = 3'd4;

    nxt_addr = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
    nxt_idx  = 2'(cnt_q + 3'd1);
    cap_idx  = 2'(cnt_q - 3'd1);

    case (state_q)
      S_IDLE: begin
        // A done pulse in flight forces one turnaround cycle before the next grant
        if (!if_done && !mem_done && (if_req || mem_req)) begin
          own_if_d   = !grant_mem;
          base_d     = sel_addr;
          n_d        = sel_n;
          wdata_d    = sel_wdata;
          asm_d      = 32'h0;
          cnt_d      = 3'd0;
          addr_ram_d = sel_addr;
          dout_d     = sel_wdata[7:0];
          wr_d       = sel_we;
          state_d    = sel_we ? S_WR : S_RD;
        end
      end
      S_RD: begin
        // Address issue leads data capture by two edges
        cnt_d = cnt_q + 3'd1;
        if (cnt_q + 3'd1 < n_q) addr_ram_d = nxt_addr;
        if (cnt_q != 3'd0) asm_d[{cap_idx, 3'b000} +: 8] = din_ram;
        if (cnt_q == n_q) begin
          state_d = S_IDLE;
          if (own_if_q) begin
            if_inst_d = asm_d;
            if_done_d = 1'b1;
          end else begin
            mem_rdata_d = asm_d;
            mem_done_d  = 1'b1;
          end
        end
      end
      S_WR: begin
        if (cnt_q + 3'd1 < n_q) begin
          cnt_d      = cnt_q + 3'd1;
          addr_ram_d = nxt_addr;
          dout_d     = wdata_q[{nxt_idx, 3'b000} +: 8];
          wr_d       = 1'b1;
        end else begin
          state_d    = S_IDLE;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      n_q       <= 3'd0;
      own_if_q  <= 1'b0;
      base_q    <= '0;
      wdata_q   <= 32'h0;
      asm_q     <= 32'h0;
      dout_ram  <= 8'h0;
      addr_ram  <= '0;
      wr_ram    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_inst   <= 32'h0;
      mem_rdata <= 32'h0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      own_if_q  <= own_if_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      asm_q     <= asm_d;
      dout_ram  <= dout_d;
      addr_ram  <= addr_ram_d;
      wr_ram    <= wr_d;
      if_done   <= if_done_d;
      mem_done  <= mem_done_d;
      if_inst   <= if_inst_d;
      mem_rdata <= mem_rdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port.
- Shares the port between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Sequences each access as a run of consecutive byte transfers, little-endian.
- IF always fetches 32-bit words; MEM issues byte, half or word reads and writes; results and completions are returned per requester.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- MEM_FIRST, 1, arbitration priority when both requests are pending in IDLE: 1 = MEM wins, 0 = IF wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- din_ram  in  8  RAM read data; valid the cycle after the RAM registers addr_ram
- dout_ram  out  8  RAM write data
- addr_ram  out  ADDR_WIDTH  RAM byte address
- wr_ram  out  1  1 = write, 0 = read
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high
- if_done  out  1  one-cycle completion pulse
- if_inst  out  32  fetched word; valid while if_done is high, held afterwards
- mem_req  in  1  load/store request; held until mem_done
- mem_we  in  1  1 = store
- mem_len  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- mem_addr  in  ADDR_WIDTH  byte address
- mem_wdata  in  32  store data; byte k = bits [8k+7:8k]
- mem_done  out  1  one-cycle completion pulse
- mem_rdata  out  32  load data, zero-extended; unused upper bytes are 0
- busy  out  1  high while in RD or WR state

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0. Reset mid-transaction aborts it on the same edge: wr_ram goes 0 and no done pulse is produced.
- States: IDLE, RD, WR. N = byte count (1/2/4). k = byte index.
- IDLE grant, at edge G:
  - Grant happens only if no done is high in the current cycle. This gives a one-cycle turnaround, and a requester must drop req or present a new request in the cycle after its done.
  - Priority between requesters follows MEM_FIRST.
  - On grant, latch owner, address, N, we and wdata; clear the assembly register.
  - Drive addr_ram = addr, dout_ram = wdata[7:0], wr_ram = we.
  - Go to RD or WR.
- RD:
  - Issue address addr+k at edge G+k, for k = 0..N-1; wr_ram stays 0.
  - Capture din_ram into byte k of the assembly register at edge G+k+2.
  - At edge G+N+1: last byte captured; the owner's data output is updated with the complete value, the owner's done goes 1 for one cycle, state returns to IDLE.
  - IF word read: if_done is high in the cycle after edge G+5.
- WR:
  - At edge G+k, drive addr_ram = addr+k, dout_ram = wdata byte k, wr_ram = 1, for k = 0..N-1.
  - At edge G+N: wr_ram = 0, mem_done = 1, state returns to IDLE.
  - IF never writes.
- Address arithmetic: addr+k is computed modulo 2^ADDR_WIDTH. No alignment requirement; misaligned half and word accesses are legal.
- Idle outputs: addr_ram holds its last value; wr_ram is 0 whenever not in a WR byte cycle.
- Stability: if_inst and mem_rdata change only on that requester's own completion edge.
- Requester changes: a request dropped mid-transaction is ignored; the transaction completes and done still pulses. Request fields changed mid-transaction are ignored, because they were latched at grant.
- Simultaneous requests: exactly one grant per IDLE cycle. The loser keeps waiting and is granted at the first eligible IDLE edge after the winner's done cycle.
- Done exclusivity: if_done and mem_done are never high in the same cycle.

Test Plan:
- IF word fetch: RAM[0x100..0x103] = 13,05,10,00; if_req, if_addr = 0x100 -> addr_ram steps 0x100..0x103 with wr_ram = 0; if_done pulses once, 6 cycles after grant; if_inst = 0x00100513.
- MEM byte store then load: mem_we = 1, len = 00, addr = 0x20, wdata = 0xAABBCCDD -> one write cycle, RAM[0x20] = 0xDD, mem_done pulses. Follow-up load of byte 0x20 -> mem_rdata = 0x000000DD.
- Simultaneous requests, MEM_FIRST = 1: if_req and a word load at 0x200 asserted together -> mem_done first. IF is granted after the turnaround cycle, and if_done follows 6 cycles after its grant.
- Half store across wrap: addr = 0xFFFFFFFF, wdata = 0x1234 -> writes RAM[0xFFFFFFFF] = 0x34 and RAM[0x00000000] = 0x12.
- Reset at the 3rd byte of a word load -> wr_ram = 0, busy = 0, no mem_done. A new if_req after reset completes normally.
- Back-to-back IF: if_req held with a new address the cycle after if_done -> no grant in the done cycle, grant on the next edge, correct second word returned.
